// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM demultiplexer.
package tdm_pkg;

   localparam int TDM_NSLOT = 8;
   localparam int TDM_SEL_W = $clog2(TDM_NSLOT);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot counter: advances on inc, jumps to 1 on load1, flags the last slot of a frame.
module tdm_slot_cnt
   import tdm_pkg::*;
#(
   parameter  int NSLOT = TDM_NSLOT,
   localparam int SEL_W = $clog2(NSLOT)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   input  logic             i_load1,
   output logic [SEL_W-1:0] o_cnt,
   output logic             o_wrap
);

   logic [SEL_W-1:0] r_cnt;

   // NSLOT is a power of two, so the natural rollover gives the 7->0 wrap.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_cnt <= '0;
      else if (i_load1)
         r_cnt <= SEL_W'(1);
      else if (i_inc)
         r_cnt <= r_cnt + SEL_W'(1);
   end

   assign o_cnt  = r_cnt;
   assign o_wrap = (r_cnt == SEL_W'(NSLOT - 1));

endmodule

// File: rtl/tdm_demux8.sv
// Serial-to-parallel TDM demultiplexer: locks on a slot-0 sync marker and
// reassembles each NSLOT-bit frame into a parallel word with a valid pulse.
module tdm_demux8
   import tdm_pkg::*;
#(
   parameter  int NSLOT = TDM_NSLOT,
   localparam int SEL_W = $clog2(NSLOT)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic             i_d,
   output logic [NSLOT-1:0] o_out,
   output logic             o_valid,
   output logic [SEL_W-1:0] o_slot,
   output logic             o_locked,
   output logic             o_sync_err
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [NSLOT-1:0] r_buf;
   logic [NSLOT-1:0] r_out;
   logic             r_valid;
   logic             r_sync_err;

   logic [SEL_W-1:0] w_slot;
   logic             w_wrap;
   logic             w_accept;
   logic             w_resync;
   logic             w_advance;
   logic             w_frame_done;

   assign w_accept     = (r_state == HUNT)   && i_en && i_sync;
   assign w_resync     = (r_state == LOCKED) && i_en && i_sync && (w_slot != '0);
   assign w_advance    = (r_state == LOCKED) && i_en && !w_resync;
   assign w_frame_done = w_advance && w_wrap;

   tdm_slot_cnt #(.NSLOT(NSLOT)) u_slot_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (w_advance),
      .i_load1 (w_accept || w_resync),
      .o_cnt   (w_slot),
      .o_wrap  (w_wrap)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_state <= HUNT;
      else
         r_state <= w_state_nxt;
   end

   // Once locked, only reset returns to HUNT; resyncs stay in LOCKED.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         HUNT:    if (w_accept) w_state_nxt = LOCKED;
         LOCKED:  w_state_nxt = LOCKED;
         default: w_state_nxt = HUNT;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_buf      <= '0;
         r_out      <= '0;
         r_valid    <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         r_valid    <= 1'b0;
         r_sync_err <= 1'b0;
         if (w_accept || w_resync) begin
            r_buf      <= '0;
            r_buf[0]   <= i_d;
            r_sync_err <= w_resync;
         end else if (w_frame_done) begin
            r_out   <= {i_d, r_buf[NSLOT-2:0]};
            r_valid <= 1'b1;
            r_buf   <= '0;
         end else if (w_advance) begin
            r_buf[w_slot] <= i_d;
         end
      end
   end

   assign o_out      = r_out;
   assign o_valid    = r_valid;
   assign o_slot     = w_slot;
   assign o_locked   = (r_state == LOCKED);
   assign o_sync_err = r_sync_err;

endmodule
